// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared FSM state encoding and mode constants for the N-channel scan mux.
package mux_scan_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2
    } state_t;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;
endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: finds the next active channel after ch in round-robin order.
module mux_scan_next_ch #(
    parameter int NUM_CH = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [SEL_W-1:0]  ch,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  next,
    output logic              wrapped,
    output logic              none_active
);
    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
    logic [SEL_W:0] sum;
    logic [SEL_W-1:0] idx;
    logic found;
    always_comb begin
        next = ch;
        wrapped = 1'b0;
        found = 1'b0;
        sum = '0;
        idx = '0;
        none_active = ~|mask;
        // i == NUM_CH lands back on ch itself, so a lone active channel wraps onto itself
        for (int i = 1; i <= NUM_CH; i++) begin
            sum = {1'b0, ch} + (SEL_W+1)'(i);
            idx = sum >= NCH ? SEL_W'(sum - NCH) : sum[SEL_W-1:0];
            if (mask[idx] && !found) begin
                found = 1'b1;
                next = idx;
                wrapped = sum >= NCH;
            end
        end
    end
endmodule

// File: rtl/mux_scan_nch.sv
// mux_scan_nch: registered N-channel mux with manual select and dwell-timed auto-scan.
// Optional MUX_SCAN_MASK_EN adds mask_in to skip/blank inactive channels.
module mux_scan_nch
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 1,
    parameter int DWELL_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     en_in,
    input  logic                     mode_in,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [DWELL_W-1:0]       dwell_in,
    input  logic [NUM_CH*DATA_W-1:0] d_in,
`ifdef MUX_SCAN_MASK_EN
    input  logic [NUM_CH-1:0]        mask_in,
`endif
    output logic [DATA_W-1:0]        y_out,
    output logic [SEL_W-1:0]         ch_out,
    output logic                     ch_valid_out,
    output logic                     wrap_out
);
    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
    state_t state;
    logic [DWELL_W-1:0] cnt, lim_m1;
    logic [SEL_W-1:0] next_ch, step_ch;
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [DATA_W-1:0] slice;
    logic auto_run, adv, step_wrap, act, sel_ok;
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_data[k] = d_in[k*DATA_W +: DATA_W];
    end
`ifdef MUX_SCAN_MASK_EN
    logic none;
    mux_scan_next_ch #(.NUM_CH(NUM_CH)) u_next (
        .ch(ch_out),
        .mask(mask_in),
        .next(step_ch),
        .wrapped(step_wrap),
        .none_active(none)
    );
    assign act = mask_in[next_ch] & ~none;
`else
    assign step_ch = ch_out == LAST ? '0 : ch_out + SEL_W'(1);
    assign step_wrap = ch_out == LAST;
    assign act = 1'b1;
`endif
    always_comb begin
        sel_ok = {1'b0, sel_in} < NCH;
        auto_run = state == ST_AUTO && mode_in == MODE_AUTO;
        lim_m1 = dwell_in == '0 ? '0 : dwell_in - DWELL_W'(1);
        // >= so a dwell shortened below the running count advances immediately
        adv = auto_run && cnt >= lim_m1;
        next_ch = mode_in == MODE_MANUAL ? (sel_ok ? sel_in : ch_out) : (adv ? step_ch : ch_out);
        slice = act ? ch_data[next_ch] : '0;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
            cnt <= '0;
            ch_out <= '0;
            y_out <= '0;
            ch_valid_out <= 1'b0;
            wrap_out <= 1'b0;
        end else if (en_in) begin
            state <= mode_in == MODE_AUTO ? ST_AUTO : ST_MANUAL;
            cnt <= auto_run && !adv ? cnt + DWELL_W'(1) : '0;
            ch_out <= next_ch;
            y_out <= slice;
            ch_valid_out <= next_ch != ch_out;
            wrap_out <= adv && step_wrap;
        end else begin
            ch_valid_out <= 1'b0;
            wrap_out <= 1'b0;
        end
    end
endmodule

// File: doc/mux_scan_nch.md
Name: mux_scan_nch

Overview:
Parameterised N-channel registered multiplexer with manual and auto-scan selection modes. It is the clocked successor to the combinational 8-to-1 mux. It adds a configurable data width, a configurable channel count, a dwell-timed round-robin scanner, and a registered output that carries the channel tag. It sits between a bank of parallel sources and a single serial consumer.

Parameters:
- NUM_CH, 8, number of input channels (>=2; need not be a power of 2).
- DATA_W, 1, width of each channel in bits.
- DWELL_W, 8, width of the dwell-count input.
- SEL_W (localparam) = $clog2(NUM_CH), channel index width.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- en_in  input  1  block enable; when low, all state and outputs hold.
- mode_in  input  1  0 = manual select, 1 = auto-scan.
- sel_in  input  SEL_W  manual channel select.
- dwell_in  input  DWELL_W  cycles spent per channel in auto mode; 0 is treated as 1.
- d_in  input  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- y_out  output  DATA_W  registered selected data.
- ch_out  output  SEL_W  channel index that y_out currently carries.
- ch_valid_out  output  1  one-cycle pulse when ch_out changes value.
- wrap_out  output  1  one-cycle pulse when auto-scan wraps from NUM_CH-1 to 0.

Behaviour:
- Reset (async, rst_in=1):
  - y_out=0, ch_out=0, ch_valid_out=0, wrap_out=0.
  - Dwell counter = 0, FSM = IDLE.
  - Release is synchronous to the next clk_in edge.
- FSM states: IDLE, MANUAL, AUTO.
  - IDLE -> MANUAL or AUTO on the first edge with en_in=1, according to mode_in.
  - MANUAL <-> AUTO on any enabled edge where mode_in differs from the current state.
  - Any state -> IDLE only by reset. en_in=0 freezes the current state.
- Datapath:
  - next_ch is computed combinationally.
  - At each enabled edge: ch_out <= next_ch and y_out <= d_in slice[next_ch], both at the same edge. Latency from d_in to y_out is one cycle.
  - ch_out and y_out are always mutually consistent.
- MANUAL:
  - next_ch = sel_in when sel_in < NUM_CH; otherwise next_ch = ch_out (out-of-range select is ignored and the channel held).
  - Dwell counter is held at 0.
- AUTO:
  - Dwell counter increments each enabled cycle.
  - When counter == max(dwell_in,1)-1: counter <= 0 and next_ch = (ch_out==NUM_CH-1) ? 0 : ch_out+1. Otherwise next_ch = ch_out.
  - A change of dwell_in mid-dwell takes effect on the compare in the same cycle. If the counter is already >= the new limit, advance on that cycle.
- Mode switches:
  - MANUAL->AUTO: scan starts from the current ch_out with the counter cleared.
  - AUTO->MANUAL: on the switching edge, next_ch = sel_in and the counter is cleared.
- Pulses:
  - ch_valid_out=1 for exactly the cycle after an edge where ch_out changed value. This includes the first enabled edge out of IDLE if the channel is nonzero.
  - wrap_out=1 for the cycle after an AUTO advance from NUM_CH-1 to 0.
  - Both pulses are 0 while en_in=0.
- Data change without a channel change: y_out tracks the data with 1-cycle latency and ch_valid_out does not pulse.

Optional Feature:
MUX_SCAN_MASK_EN.
- Defined:
  - Adds port mask_in input NUM_CH (1 = channel active).
  - AUTO advances to the next active channel in round-robin order after ch_out. wrap_out pulses if the search passes index NUM_CH-1.
  - If all channels are masked: ch_out holds and y_out is forced to 0.
  - In MANUAL, selecting a masked channel loads ch_out normally but forces y_out to 0.
- Undefined: the mask_in port does not exist and all channels are active.

Decomposition:
- Package mux_scan_pkg holds:
  - state encoding constants (ST_IDLE=2'd0, ST_MANUAL=2'd1, ST_AUTO=2'd2);
  - mode constants MODE_MANUAL=1'b0 and MODE_AUTO=1'b1.
- One sub-module is natural: mux_scan_next_ch, a combinational round-robin next-active-channel finder with inputs ch, mask and outputs next, wrapped, none_active. It is used only under MUX_SCAN_MASK_EN.

Test Plan (NUM_CH=8, DATA_W=1):
- Reset check: assert rst_in mid-AUTO at ch_out=5 -> y_out, ch_out, ch_valid_out and wrap_out all go to 0 immediately, without waiting for a clock edge.
- MANUAL: sel_in=3, d_in=8'b0000_1000 -> next cycle y_out=1, ch_out=3, one ch_valid_out pulse. Then d_in=0 -> y_out=0 with no pulse.
- AUTO with dwell_in=5, starting from ch 0:
  - ch_out advances every 5 cycles: 0->1->...->7->0.
  - wrap_out pulses once after 40 cycles.
  - ch_valid_out pulses 8 times per sweep.
- dwell_in=0 in AUTO -> channel advances every cycle. Hold en_in=0 for 3 cycles mid-scan -> y_out and ch_out frozen, no pulses.
- Mode switch in AUTO at ch_out=6 with mode_in=0 and sel_in=2 -> next cycle ch_out=2. Switch back -> scan resumes at 2 with the dwell count restarted.
- MUX_SCAN_MASK_EN:
  - mask_in=8'b1000_0101, AUTO, dwell_in=1 -> ch_out sequence 0,2,7,0 with wrap_out on the 7->0 step.
  - mask_in=0 -> y_out=0 and ch_out held.
